// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, response and memory-port signals shared by the arbiter and its neighbours
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    en;
   logic                    if_req;
   logic [ADDR_WIDTH-1:0]   if_addr;
   logic                    if_ready;
   logic                    if_rvalid;
   logic [DATA_WIDTH-1:0]   if_rdata;
   logic                    d_req;
   logic                    d_we;
   logic [ADDR_WIDTH-1:0]   d_addr;
   logic [DATA_WIDTH-1:0]   d_wdata;
   logic [DATA_WIDTH/8-1:0] d_wstrb;
   logic                    d_ready;
   logic                    d_rvalid;
   logic [DATA_WIDTH-1:0]   d_rdata;
   logic                    mem_req;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH/8-1:0] mem_wstrb;
   logic                    mem_ack;
   logic [DATA_WIDTH-1:0]   mem_rdata;
   modport master (
      output en, if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
      input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
   modport slave (
      input  en, if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
      output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters; define ARB_ROUND_ROBIN_EN for alternating priority
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic              clk,
   input logic              rstn,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
   state_t                  r_state, w_next;
   logic                    w_pick_d, w_grant, w_ack;
   logic                    r_mem_req, r_mem_we, r_if_rvalid, r_d_rvalid;
   logic [ADDR_WIDTH-1:0]   r_mem_addr;
   logic [DATA_WIDTH-1:0]   r_mem_wdata, r_if_rdata, r_d_rdata;
   logic [DATA_WIDTH/8-1:0] r_mem_wstrb;
`ifdef ARB_ROUND_ROBIN_EN
   logic                    r_last_d;
   // remember the last owner so a contested grant goes to the other port
   always_ff @(posedge clk) r_last_d <= !rstn ? 1'b1 : (w_grant ? w_pick_d : r_last_d);
   assign w_pick_d = bus.d_req & (~bus.if_req | ~r_last_d);
`else
   assign w_pick_d = bus.d_req;
`endif
   assign w_grant      = (r_state == IDLE) & bus.en & (bus.if_req | bus.d_req);
   assign w_ack        = (r_state != IDLE) & bus.mem_ack;
   assign bus.d_ready  = w_grant & w_pick_d;
   assign bus.if_ready = w_grant & ~w_pick_d;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_wstrb = r_mem_wstrb;
   assign bus.if_rvalid = r_if_rvalid;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.d_rvalid  = r_d_rvalid;
   assign bus.d_rdata   = r_d_rdata;
   // next state: grant from IDLE, return to IDLE on the memory ack
   always_comb begin
      w_next = r_state;
      if (w_grant) w_next = w_pick_d ? BUSY_D : BUSY_I;
      else if (w_ack) w_next = IDLE;
   end
   // state, latched command and one-cycle response registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state     <= IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wstrb <= '0;
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
      end else begin
         r_state     <= w_next;
         r_if_rvalid <= w_ack & (r_state == BUSY_I);
         r_d_rvalid  <= w_ack & (r_state == BUSY_D);
         if (w_ack && r_state == BUSY_I) r_if_rdata <= bus.mem_rdata;
         if (w_ack && r_state == BUSY_D) r_d_rdata <= bus.mem_rdata;
         if (w_grant) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_pick_d & bus.d_we;
            r_mem_addr  <= w_pick_d ? bus.d_addr : bus.if_addr;
            r_mem_wdata <= w_pick_d ? bus.d_wdata : '0;
            r_mem_wstrb <= w_pick_d ? bus.d_wstrb : '0;
         end else if (w_ack) begin
            r_mem_req <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a transaction-level reference model checked every cycle
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic chk_on = 1'b0;
   int   lat = 1;
   int   m_cnt = 0;
   logic force_ack = 1'b0;
   logic use_fixed = 1'b0;
   logic [31:0] fixed_rd = '0;

   mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // memory: acks in the lat-th cycle that mem_req is high; force_ack injects a stray ack
   always @(posedge clk) begin
      #2;
      if (bus.mem_req) m_cnt = m_cnt + 1;
      else m_cnt = 0;
      bus.mem_ack   = force_ack | (bus.mem_req && m_cnt == lat);
      bus.mem_rdata = use_fixed ? fixed_rd : (bus.mem_addr ^ 32'h5A5A_0000);
   end

   // reference model: who owns the memory, the command it asked for, pending responses
   int          m_owner = 0;
   logic        m_we = 0, m_rv_i = 0, m_rv_d = 0, m_last_d = 1, m_rst = 0;
   logic [31:0] m_addr = 0, m_wdata = 0, m_rd_i = 0, m_rd_d = 0;
   logic [3:0]  m_wstrb = 0;

   function automatic logic data_wins();
      if (bus.d_req && bus.if_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         return !m_last_d;
`else
         return 1'b1;
`endif
      end
      return bus.d_req;
   endfunction

   always @(posedge clk) begin
      m_rst <= !rstn;
      if (!rstn) begin
         m_owner <= 0; m_rv_i <= 0; m_rv_d <= 0; m_rd_i <= 0; m_rd_d <= 0; m_last_d <= 1;
      end else begin
         m_rv_i <= m_owner == 1 && bus.mem_ack;
         m_rv_d <= m_owner == 2 && bus.mem_ack;
         if (m_owner == 1 && bus.mem_ack) begin m_owner <= 0; m_rd_i <= bus.mem_rdata; end
         if (m_owner == 2 && bus.mem_ack) begin m_owner <= 0; m_rd_d <= bus.mem_rdata; end
         if (m_owner == 0 && bus.en && (bus.if_req || bus.d_req)) begin
            m_owner  <= data_wins() ? 2 : 1;
            m_last_d <= data_wins();
            m_we     <= data_wins() && bus.d_we;
            m_addr   <= data_wins() ? bus.d_addr : bus.if_addr;
            m_wdata  <= data_wins() ? bus.d_wdata : 32'h0;
            m_wstrb  <= data_wins() ? bus.d_wstrb : 4'h0;
         end
      end
   end

   // compare DUT against the model on every falling edge
   always @(negedge clk) begin
      if (chk_on) begin
         chk("if_ready", bus.if_ready, m_owner == 0 && bus.en && bus.if_req && !data_wins());
         chk("d_ready", bus.d_ready, m_owner == 0 && bus.en && bus.d_req && data_wins());
         chk("mem_req", bus.mem_req, m_owner != 0);
         chk("if_rvalid", bus.if_rvalid, m_rv_i);
         chk("d_rvalid", bus.d_rvalid, m_rv_d);
         if (m_owner != 0) begin
            chk("mem_we", bus.mem_we, m_we);
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("mem_wdata", bus.mem_wdata, m_wdata);
            chk("mem_wstrb", bus.mem_wstrb, m_wstrb);
         end
         if (m_rv_i) chk("if_rdata", bus.if_rdata, m_rd_i);
         if (m_rv_d) chk("d_rdata", bus.d_rdata, m_rd_d);
         if (m_rst) begin
            chk("rst_mem_we", bus.mem_we, 0);
            chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_mem_wdata", bus.mem_wdata, 0);
            chk("rst_mem_wstrb", bus.mem_wstrb, 0);
            chk("rst_if_rdata", bus.if_rdata, 0);
            chk("rst_d_rdata", bus.d_rdata, 0);
         end
      end
   end

   logic g[4];
   logic exp_g[4];
   int   n;
   logic got;

   initial begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      bus.en = 1'b1; bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
      bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
      tick();
      chk_on = 1'b1;
      repeat (2) tick();
      #2;
      chk("reset_mem_req", bus.mem_req, 0);
      chk("reset_if_rvalid", bus.if_rvalid, 0);
      tick();
      rstn = 1'b1;

      // single fetch, ack in the third mem_req cycle
      tick();
      bus.if_req = 1; bus.if_addr = 32'h100; use_fixed = 1; fixed_rd = 32'h0050_0093; lat = 3;
      #2;
      chk("fetch_ready_c0", bus.if_ready, 1);
      chk("fetch_memreq_c0", bus.mem_req, 0);
      tick();
      bus.if_req = 0;
      for (int c = 1; c <= 3; c++) begin
         #2;
         chk("fetch_memreq", bus.mem_req, 1);
         chk("fetch_addr", bus.mem_addr, 32'h100);
         chk("fetch_we", bus.mem_we, 0);
         tick();
      end
      #2;
      chk("fetch_rvalid_c4", bus.if_rvalid, 1);
      chk("fetch_rdata_c4", bus.if_rdata, 32'h0050_0093);
      chk("fetch_no_d_rvalid", bus.d_rvalid, 0);
      use_fixed = 0;

      // store with single-cycle ack
      tick();
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2004; bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'hF; lat = 1;
      #2;
      chk("store_ready", bus.d_ready, 1);
      tick();
      bus.d_req = 0; bus.d_we = 0;
      #2;
      chk("store_we", bus.mem_we, 1);
      chk("store_wstrb", bus.mem_wstrb, 4'hF);
      chk("store_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("store_addr", bus.mem_addr, 32'h2004);
      tick();
      #2;
      chk("store_rvalid", bus.d_rvalid, 1);
      chk("store_memreq_low", bus.mem_req, 0);
      tick();
      #2;
      chk("store_rvalid_drop", bus.d_rvalid, 0);

      // contention over four transfers
      tick();
      bus.if_req = 1; bus.d_req = 1; bus.if_addr = 32'h80; bus.d_addr = 32'h40; lat = 1;
      n = 0;
      for (int c = 0; c < 20 && n < 4; c++) begin
         #2;
         if (bus.if_ready) begin g[n] = 1'b0; n++; end
         else if (bus.d_ready) begin g[n] = 1'b1; n++; end
         tick();
      end
      bus.if_req = 0; bus.d_req = 0;
      chk("contend_count", n, 4);
      for (int i = 0; i < 4; i++) chk("contend_owner", g[i], exp_g[i]);
      repeat (4) tick();

      // enable gating, then enable dropped mid-transfer
      bus.en = 0; bus.if_req = 1; bus.d_req = 1;
      for (int c = 0; c < 5; c++) begin
         #2;
         chk("en0_if_ready", bus.if_ready, 0);
         chk("en0_d_ready", bus.d_ready, 0);
         chk("en0_mem_req", bus.mem_req, 0);
         tick();
      end
      bus.en = 1; bus.d_req = 0; lat = 3;
      #2;
      chk("en1_if_ready", bus.if_ready, 1);
      tick();
      bus.en = 0; bus.if_req = 0;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         #2;
         if (bus.if_rvalid) got = 1;
         tick();
      end
      chk("en_drop_rvalid", got, 1);
      bus.en = 1;
      repeat (2) tick();

      // reset in the middle of a data read
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h3000; lat = 10;
      #2;
      chk("rst_d_ready", bus.d_ready, 1);
      tick();
      bus.d_req = 0;
      #2;
      chk("rst_busy_memreq", bus.mem_req, 1);
      tick();
      rstn = 0;
      tick();
      rstn = 1;
      #2;
      chk("rst_mid_memreq", bus.mem_req, 0);
      chk("rst_mid_addr", bus.mem_addr, 0);
      chk("rst_mid_d_rdata", bus.d_rdata, 0);
      chk("rst_mid_if_rdata", bus.if_rdata, 0);
      tick();
      force_ack = 1;
      tick();
      force_ack = 0;
      for (int c = 0; c < 2; c++) begin
         #2;
         chk("stray_ack_d_rvalid", bus.d_rvalid, 0);
         chk("stray_ack_if_rvalid", bus.if_rvalid, 0);
         tick();
      end

      // back-to-back fetches, one transfer every two cycles
      bus.if_req = 1; bus.if_addr = 32'h200; lat = 1;
      for (int c = 0; c < 8; c++) begin
         #2;
         chk("b2b_if_ready", bus.if_ready, c % 2 == 0);
         chk("b2b_if_rvalid", bus.if_rvalid, c >= 2 && c % 2 == 0);
         tick();
      end
      bus.if_req = 0;
      repeat (3) tick();

      chk_on = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between the core's instruction-fetch port and its load/store data port. It accepts one request at a time and latches its address and write data. It then drives the memory port until the memory acknowledges, and returns a one-cycle response to the requester that owns the transfer. It sits between the RV32 core and the memory model, and lets the core run with a multi-cycle memory.

## Interface
- ADDR_WIDTH, 32, address width of both requesters and the memory port
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  synchronous active-low reset, sampled on rising edge of clk
- en  in  1  arbiter enable; 0 blocks new grants
- if_req / if_addr  in  1 / ADDR_WIDTH  fetch request (always a read) and its address
- if_ready  out  1  fetch request accepted this cycle
- if_rvalid / if_rdata  out  1 / DATA_WIDTH  fetch response pulse and its data
- d_req / d_we / d_addr / d_wdata / d_wstrb  in  1 / 1 / ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  data request
- d_ready  out  1  data request accepted this cycle
- d_rvalid / d_rdata  out  1 / DATA_WIDTH  data response pulse; asserted for both reads and writes
- mem_req / mem_we / mem_addr / mem_wdata / mem_wstrb  out  memory port command, held stable while mem_req=1
- mem_ack  in  1  one-cycle completion from memory; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- **IDLE, arbitration.** With en=1 and at least one req: select one owner, pulse its ready, latch its command into the command registers, and go to the matching BUSY state.
  - A fetch latches we=0 and wstrb=0.
  - Requests are level signals and need not be held after the ready pulse.
- **Default arbitration** is fixed priority: data before fetch.
- **BUSY_x.** mem_req=1 with the latched command. On mem_ack: latch mem_rdata into the response register, set the owner's rvalid for the next cycle, and go to IDLE.
  - The rdata register keeps its value after rvalid drops.
- **Response cycle.** rvalid is high for exactly one cycle, in IDLE. Arbitration runs normally in that same cycle, so back-to-back transfers carry no bubble beyond the response cycle.
- **en=0.**
  - In IDLE: no grant and no ready.
  - In BUSY: the outstanding transfer still completes and its rvalid is still issued.
- **Ignored inputs.** mem_ack in IDLE is ignored. Requests arriving in BUSY wait; they are neither dropped nor acknowledged.
- **Write data to the requester.** For a write, d_rdata returns mem_rdata as sampled with the ack. The requester must not use it.
- **Reset.** rstn=0 at any edge, including mid-transfer, has these effects:
  - The state goes to IDLE.
  - Every output goes to 0: ready, rvalid, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_rdata, d_rdata.
  - The abandoned transfer produces no response. A mem_ack arriving after reset is ignored.

## Timing
- Request seen at edge N with the arbiter in IDLE: ready is combinational in cycle N, mem_req is first high in cycle N+1, and an ack in cycle N+k (k≥1) gives rvalid in cycle N+k+1. Minimum request-to-response latency is 2 cycles.
- Ready is a combinational function of state, en and the req inputs. All other outputs are registered.
- mem_req falls in the cycle after mem_ack. Memory must not ack twice for one command.
- One transfer is outstanding at most. Throughput is one transfer per k+1 cycles.

## Configuration
- ARB_ROUND_ROBIN_EN defined: a 1-bit last-owner register, reset to "data", decides simultaneous requests.
  - When both req are high in IDLE, the port not granted last wins. The first simultaneous contest after reset therefore goes to fetch.
  - A lone request is always granted and updates last-owner.
- Not defined: fixed data-over-fetch priority and no last-owner register. Fetch can starve while the data port requests continuously.

## Test plan
- **Single fetch.** if_req=1, if_addr=0x100; memory acks 3 cycles after mem_req rises with rdata=0x00500093. Required:
  - if_ready in cycle 0;
  - mem_req in cycles 1–3 with mem_addr=0x100 and mem_we=0;
  - if_rvalid=1 in cycle 4 with if_rdata=0x00500093;
  - d_rvalid never asserted.
- **Store.** d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_wstrb=0xF; ack after 1 cycle. Required:
  - mem_we=1, mem_wstrb=0xF and the same data seen at memory;
  - d_rvalid pulses one cycle;
  - mem_req is low on the next cycle.
- **Contention.** if_req and d_req both held high for 4 transfers.
  - Fixed build: all 4 grants go to data.
  - ARB_ROUND_ROBIN_EN build: grants alternate I, D, I, D.
- **Enable gating.** en=0 with both requests high for 5 cycles → no ready and no mem_req. Dropping en mid-BUSY → the transfer completes and rvalid is still issued.
- **Reset mid-transfer.** rstn=0 while in BUSY_D with mem_req=1 → next cycle all outputs are 0 and the state is IDLE. A later stray mem_ack produces no rvalid.
- **Back-to-back.** if_req held high, ack latency 1 → a new if_ready in the same cycle as each if_rvalid, for one transfer every 2 cycles.
